// File: rtl/dram_store_pkg.sv
// Shared types and width helpers for the per-channel DRAM backing store.
package dram_store_pkg;

  typedef enum logic [1:0] {
    e_map_ch_low       = 2'd0,
    e_map_ch_above_col = 2'd1,
    e_map_ch_top       = 2'd2
  } addr_map_e;

  typedef enum logic {
    e_xlate_map   = 1'b0,
    e_xlate_unmap = 1'b1
  } xlate_dir_e;

  function automatic int calc_bo(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_cw(input int num_columns);
    return $clog2(num_columns);
  endfunction

  function automatic int calc_lc(input int num_channels);
    return $clog2(num_channels);
  endfunction

  function automatic int calc_mw(input int chw, input int num_channels);
    return chw + calc_lc(num_channels);
  endfunction

  // Bit position of the lowest channel-field bit inside the global address.
  function automatic int calc_ch_pos(input addr_map_e mode, input int chw,
                                     input int bo, input int cw);
    case (mode)
      e_map_ch_low:       return bo;
      e_map_ch_above_col: return bo + cw;
      default:            return chw;
    endcase
  endfunction

endpackage

// File: rtl/dram_channel_store_if.sv
// Request / completion bundle between the timing-model wrapper and one channel store.
interface dram_channel_store_if
  import dram_store_pkg::*;
#(
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 64,
  parameter int num_channels_p       = 2
) ();
  localparam int mw_lp = calc_mw(channel_addr_width_p, num_channels_p);

  logic [channel_addr_width_p-1:0] ch_addr_i;
  logic [mw_lp-1:0]                mem_addr_o;
  logic                            w_v_i;
  logic [data_width_p-1:0]         w_data_i;
  logic [data_width_p/8-1:0]       w_mask_i;
  logic                            rd_done_v_i;
  logic [mw_lp-1:0]                rd_done_mem_addr_i;
  logic                            data_v_o;
  logic [data_width_p-1:0]         data_o;
  logic [channel_addr_width_p-1:0] data_ch_addr_o;
  logic                            chan_err_o;

  modport master (
    output ch_addr_i, w_v_i, w_data_i, w_mask_i, rd_done_v_i, rd_done_mem_addr_i,
    input  mem_addr_o, data_v_o, data_o, data_ch_addr_o, chan_err_o
  );

  modport slave (
    input  ch_addr_i, w_v_i, w_data_i, w_mask_i, rd_done_v_i, rd_done_mem_addr_i,
    output mem_addr_o, data_v_o, data_o, data_ch_addr_o, chan_err_o
  );
endinterface

// File: rtl/dram_ch_addr_xlate.sv
// Inserts (map) or removes (unmap) the channel field of a DRAM address; purely combinational.
module dram_ch_addr_xlate
  import dram_store_pkg::*;
#(
  parameter int         chw_p    = 16,
  parameter int         lc_p     = 1,
  parameter int         ch_pos_p = 3,
  parameter int         sel_p    = 0,
  parameter xlate_dir_e dir_p    = e_xlate_map,
  localparam int mw_lp  = chw_p + lc_p,
  localparam int in_w_lp  = (dir_p == e_xlate_map) ? chw_p : mw_lp,
  localparam int out_w_lp = (dir_p == e_xlate_map) ? mw_lp : chw_p
) (
  input  logic [in_w_lp-1:0]  addr_i,
  output logic [out_w_lp-1:0] addr_o,
  output logic                chan_err_o
);
  localparam logic [mw_lp-1:0] chan_mask_lp = mw_lp'((1 << lc_p) - 1) << ch_pos_p;
  localparam logic [mw_lp-1:0] sel_field_lp = mw_lp'(sel_p) << ch_pos_p;

  logic [mw_lp-1:0] low_mask;

  for (genvar gi = 0; gi < mw_lp; gi++) begin : g_low_mask
    assign low_mask[gi] = (gi < ch_pos_p);
  end

  if (dir_p == e_xlate_map) begin : g_map
    logic [mw_lp-1:0] addr_ext;
    assign addr_ext   = mw_lp'(addr_i);
    assign addr_o     = ((addr_ext >> ch_pos_p) << (ch_pos_p + lc_p))
                      | (sel_field_lp & chan_mask_lp)
                      | (addr_ext & low_mask);
    assign chan_err_o = 1'b0;
  end else begin : g_unmap
    assign addr_o     = chw_p'(((addr_i >> (ch_pos_p + lc_p)) << ch_pos_p)
                      | (addr_i & low_mask));
    assign chan_err_o = ((addr_i ^ sel_field_lp) & chan_mask_lp) != '0;
  end

endmodule

// File: rtl/dram_channel_store.sv
// Per-channel backing store: address mapping, byte-masked word array, 1-cycle read return.
module dram_channel_store
  import dram_store_pkg::*;
#(
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 64,
  parameter int num_channels_p       = 2,
  parameter int num_columns_p        = 32,
  parameter int address_mapping_p    = 0,
  parameter int channel_select_p     = 0,
  parameter int masked_p             = 1,
  parameter int init_mem_p           = 0
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  dram_channel_store_if.slave bus
);
  localparam int chw_lp     = channel_addr_width_p;
  localparam int bo_lp      = calc_bo(data_width_p);
  localparam int lc_lp      = calc_lc(num_channels_p);
  localparam int mask_w_lp  = data_width_p / 8;
  localparam int word_aw_lp = chw_lp - bo_lp;
  localparam int words_lp   = 1 << word_aw_lp;
  localparam int ch_pos_lp  = calc_ch_pos(addr_map_e'(address_mapping_p), chw_lp, bo_lp,
                                          calc_cw(num_columns_p));

  logic [chw_lp-1:0] rd_ch_addr;
  logic              rd_chan_err;

  dram_ch_addr_xlate #(
    .chw_p(chw_lp), .lc_p(lc_lp), .ch_pos_p(ch_pos_lp),
    .sel_p(channel_select_p), .dir_p(e_xlate_map)
  ) u_map (
    .addr_i(bus.ch_addr_i),
    .addr_o(bus.mem_addr_o),
    .chan_err_o()
  );

  dram_ch_addr_xlate #(
    .chw_p(chw_lp), .lc_p(lc_lp), .ch_pos_p(ch_pos_lp),
    .sel_p(channel_select_p), .dir_p(e_xlate_unmap)
  ) u_unmap (
    .addr_i(bus.rd_done_mem_addr_i),
    .addr_o(rd_ch_addr),
    .chan_err_o(rd_chan_err)
  );

  logic [mask_w_lp-1:0]    w_mask_eff;
  logic [word_aw_lp-1:0]   w_word;
  logic [word_aw_lp-1:0]   rd_word;
  logic [data_width_p-1:0] mem_r [words_lp];

  assign w_mask_eff = (masked_p != 0) ? bus.w_mask_i : '1;
  assign w_word     = bus.ch_addr_i[chw_lp-1:bo_lp];
  assign rd_word    = rd_ch_addr[chw_lp-1:bo_lp];

  // Array has no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && bus.w_v_i) begin
      for (int k = 0; k < mask_w_lp; k++) begin
        if (w_mask_eff[k]) mem_r[w_word][8*k +: 8] <= bus.w_data_i[8*k +: 8];
      end
    end
  end

  logic                    data_v_reg;
  logic [data_width_p-1:0] data_reg;
  logic [chw_lp-1:0]       data_ch_addr_reg;
  logic                    chan_err_reg;

  // Same-word read/write in one cycle returns the old word via NBA ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_v_reg       <= 1'b0;
      data_reg         <= '0;
      data_ch_addr_reg <= '0;
      chan_err_reg     <= 1'b0;
    end else begin
      data_v_reg   <= bus.rd_done_v_i;
      chan_err_reg <= bus.rd_done_v_i & rd_chan_err;
      if (bus.rd_done_v_i) begin
        data_reg         <= mem_r[rd_word];
        data_ch_addr_reg <= rd_ch_addr;
      end
    end
  end

  assign bus.data_v_o       = data_v_reg;
  assign bus.data_o         = data_reg;
  assign bus.data_ch_addr_o = data_ch_addr_reg;
  assign bus.chan_err_o     = chan_err_reg;

endmodule

// File: tb/tb_dram_channel_store.sv
// Scoreboard bench: three stores (mapping modes 0/1/2) share clock and reset.
module tb_dram_channel_store;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dram_channel_store_if #(.channel_addr_width_p(16), .data_width_p(64), .num_channels_p(2)) bus0 ();
  dram_channel_store_if #(.channel_addr_width_p(16), .data_width_p(64), .num_channels_p(2)) bus1 ();
  dram_channel_store_if #(.channel_addr_width_p(16), .data_width_p(64), .num_channels_p(2)) bus2 ();

  dram_channel_store #(.address_mapping_p(0), .channel_select_p(1), .masked_p(1)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus0));
  dram_channel_store #(.address_mapping_p(1), .channel_select_p(1), .masked_p(0)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus1));
  dram_channel_store #(.address_mapping_p(2), .channel_select_p(1), .masked_p(1)) u_dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus2));

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
    logic        err;
    bit          data_care;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int failures = 0;

  localparam logic [63:0] A_W = 64'hDEADBEEFAAAAAAAA;
  localparam logic [63:0] B_W = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_W = 64'h0F1E2D3C4B5A6978;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic check_resp(input string nm, input exp_t e, input logic [63:0] d,
                            input logic [15:0] a, input logic err);
    if (e.data_care) cmp({nm, "_data"}, d, e.data);
    cmp({nm, "_addr"}, 64'(a), 64'(e.addr));
    cmp({nm, "_err"}, 64'(err), 64'(e.err));
  endtask

  // Monitors: pop one expectation per valid output, independent of stimulus.
  always @(negedge clk) begin
    if (reset_n && bus0.data_v_o) begin
      if (q0.size() == 0) cmp("dut0_unexpected_valid", 64'd1, 64'd0);
      else check_resp("dut0", q0.pop_front(), bus0.data_o, bus0.data_ch_addr_o, bus0.chan_err_o);
    end
  end
  always @(negedge clk) begin
    if (reset_n && bus1.data_v_o) begin
      if (q1.size() == 0) cmp("dut1_unexpected_valid", 64'd1, 64'd0);
      else check_resp("dut1", q1.pop_front(), bus1.data_o, bus1.data_ch_addr_o, bus1.chan_err_o);
    end
  end
  always @(negedge clk) begin
    if (reset_n && bus2.data_v_o) begin
      if (q2.size() == 0) cmp("dut2_unexpected_valid", 64'd1, 64'd0);
      else check_resp("dut2", q2.pop_front(), bus2.data_o, bus2.data_ch_addr_o, bus2.chan_err_o);
    end
  end

  task automatic clear_strobes();
    bus0.w_v_i = 1'b0; bus0.rd_done_v_i = 1'b0;
    bus1.w_v_i = 1'b0; bus1.rd_done_v_i = 1'b0;
    bus2.w_v_i = 1'b0; bus2.rd_done_v_i = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic set_wr(input int id, input logic [15:0] a, input logic [63:0] d, input logic [7:0] m);
    case (id)
      0: begin bus0.ch_addr_i = a; bus0.w_data_i = d; bus0.w_mask_i = m; bus0.w_v_i = 1'b1; end
      1: begin bus1.ch_addr_i = a; bus1.w_data_i = d; bus1.w_mask_i = m; bus1.w_v_i = 1'b1; end
      default: begin bus2.ch_addr_i = a; bus2.w_data_i = d; bus2.w_mask_i = m; bus2.w_v_i = 1'b1; end
    endcase
  endtask

  task automatic set_rd(input int id, input logic [16:0] ma, input logic [63:0] d,
                        input logic [15:0] a, input logic err, input bit care);
    exp_t e;
    e.data = d; e.addr = a; e.err = err; e.data_care = care;
    case (id)
      0: begin bus0.rd_done_mem_addr_i = ma; bus0.rd_done_v_i = 1'b1; q0.push_back(e); end
      1: begin bus1.rd_done_mem_addr_i = ma; bus1.rd_done_v_i = 1'b1; q1.push_back(e); end
      default: begin bus2.rd_done_mem_addr_i = ma; bus2.rd_done_v_i = 1'b1; q2.push_back(e); end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.ch_addr_i = '0; bus0.w_data_i = '0; bus0.w_mask_i = '0; bus0.rd_done_mem_addr_i = '0;
    bus1.ch_addr_i = '0; bus1.w_data_i = '0; bus1.w_mask_i = '0; bus1.rd_done_mem_addr_i = '0;
    bus2.ch_addr_i = '0; bus2.w_data_i = '0; bus2.w_mask_i = '0; bus2.rd_done_mem_addr_i = '0;
    clear_strobes();
    #1 reset_n = 1'b0;
    #1;
    cmp("reset_data_v", 64'(bus0.data_v_o), 64'd0);
    cmp("reset_data", bus0.data_o, 64'd0);
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();

    // Combinational mapping in all three modes.
    bus0.ch_addr_i = 16'h1234; bus1.ch_addr_i = 16'h1234; bus2.ch_addr_i = 16'h1234;
    #1;
    cmp("map_mode0", 64'(bus0.mem_addr_o), 64'h0246C);
    cmp("map_mode1", 64'(bus1.mem_addr_o), 64'h02534);
    cmp("map_mode2", 64'(bus2.mem_addr_o), 64'h11234);

    // Unmap round trip via completed reads.
    set_rd(0, 17'h0246C, '0, 16'h1234, 1'b0, 1'b0);
    set_rd(1, 17'h02534, '0, 16'h1234, 1'b0, 1'b0);
    set_rd(2, 17'h11234, '0, 16'h1234, 1'b0, 1'b0);
    cycle();

    // Full then partial write, read back.
    set_wr(0, 16'h0040, 64'hDEADBEEF01234567, 8'hFF); cycle();
    set_wr(0, 16'h0040, 64'h00000000AAAAAAAA, 8'h0F); cycle();
    set_rd(0, 17'h00088, A_W, 16'h0040, 1'b0, 1'b1); cycle();
    cycle();
    cmp("idle_data_v", 64'(bus0.data_v_o), 64'd0);
    cmp("idle_chan_err", 64'(bus0.chan_err_o), 64'd0);
    cmp("idle_data_hold", bus0.data_o, A_W);
    cmp("idle_addr_hold", 64'(bus0.data_ch_addr_o), 64'h0040);

    // Wrong channel field still reads.
    set_rd(0, 17'h00080, A_W, 16'h0040, 1'b1, 1'b1); cycle();

    // Same-cycle collision, then back-to-back read of new data.
    set_wr(0, 16'h0040, B_W, 8'hFF);
    set_rd(0, 17'h00088, A_W, 16'h0040, 1'b0, 1'b1); cycle();
    set_rd(0, 17'h00088, B_W, 16'h0040, 1'b0, 1'b1); cycle();

    // Independent word, mid-byte mask, byte offset ignored for data.
    set_wr(0, 16'h0048, C_W, 8'hFF); cycle();
    set_rd(0, 17'h00098, C_W, 16'h0048, 1'b0, 1'b1); cycle();
    set_rd(0, 17'h0008D, B_W, 16'h0045, 1'b0, 1'b1); cycle();
    set_wr(0, 16'h004B, 64'hFFFFFFFFFFFFFFFF, 8'h3C); cycle();
    set_rd(0, 17'h00098, 64'h0F1EFFFFFFFF6978, 16'h0048, 1'b0, 1'b1); cycle();

    // masked_p=0 instance ignores the mask.
    set_wr(1, 16'h0040, 64'h1111111111111111, 8'hFF); cycle();
    set_wr(1, 16'h0040, 64'h2222222222222222, 8'h01); cycle();
    set_rd(1, 17'h00140, 64'h2222222222222222, 16'h0040, 1'b0, 1'b1); cycle();

    // Mode 2 channel error at the top bit.
    set_rd(2, 17'h01234, '0, 16'h1234, 1'b1, 1'b0); cycle();

    // Asynchronous reset while data_v_o is high.
    set_rd(0, 17'h00088, B_W, 16'h0040, 1'b0, 1'b1); cycle();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    cmp("async_rst_data_v", 64'(bus0.data_v_o), 64'd0);
    cmp("async_rst_data", bus0.data_o, 64'd0);
    cmp("async_rst_addr", 64'(bus0.data_ch_addr_o), 64'd0);
    cmp("async_rst_err", 64'(bus0.chan_err_o), 64'd0);
    bus0.ch_addr_i = 16'h0040; bus0.w_data_i = 64'h5555555555555555; bus0.w_mask_i = 8'hFF;
    bus0.w_v_i = 1'b1; bus0.rd_done_mem_addr_i = 17'h00080; bus0.rd_done_v_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("in_rst_read_ignored", 64'(bus0.data_v_o), 64'd0);
    cmp("in_rst_err_low", 64'(bus0.chan_err_o), 64'd0);
    clear_strobes();
    reset_n = 1'b1;
    cycle();
    set_rd(0, 17'h00088, B_W, 16'h0040, 1'b0, 1'b1); cycle();
    cycle();

    cmp("q0_drained", 64'(q0.size()), 64'd0);
    cmp("q1_drained", 64'(q1.size()), 64'd0);
    cmp("q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
